// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx #(
    parameter int NUM_DATA_BITS = 8,
    parameter int NUM_STOP_BITS = 1,
    parameter int PARITY_ODD    = 0
) (
    input  logic                     baud,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_DATA_BITS-1:0] data,
    output logic                     tx,
    output logic                     done,
    output logic                     busy,
    output logic                     error
);

    localparam int CW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(NUM_DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(NUM_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
`ifdef UART_TX_PARITY_EN
    logic                     par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (en) begin
                    shift_d = data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
                state_d = S_DATA;
            end
            S_DATA: begin
                if (cnt_q == LAST_DATA) begin
                    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                    tx_d    = par_q;
                    state_d = S_PARITY;
`else
                    tx_d    = 1'b1;
                    state_d = S_STOP;
`endif
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = S_STOP;
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (cnt_q == LAST_STOP) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // A request while a frame is on the line is dropped and flagged.
        if (en && state_q != S_IDLE) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge baud or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level model for two configurations
// (8N1 even, 8N2 odd) plus literal frame patterns.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic       baud = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx1, done1, busy1, err1;
    logic       tx2, done2, busy2, err2;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] bits;
        int          pos;
        int          len;
        logic        tx;
        logic        busy;
        logic        done;
        logic        err;
    } mdl_t;

    mdl_t m1, m2;

    uart_tx u_dut (
        .baud(baud), .reset(reset), .en(en), .data(data),
        .tx(tx1), .done(done1), .busy(busy1), .error(err1)
    );

    uart_tx #(.NUM_STOP_BITS(2), .PARITY_ODD(1)) u_dut2 (
        .baud(baud), .reset(reset), .en(en), .data(data),
        .tx(tx2), .done(done2), .busy(busy2), .error(err2)
    );

    always #5 baud = ~baud;

    function automatic mdl_t idle_m();
        mdl_t r;
        r.bits = '1;
        r.pos  = 0;
        r.len  = 0;
        r.tx   = 1'b1;
        r.busy = 1'b0;
        r.done = 1'b0;
        r.err  = 1'b0;
        return r;
    endfunction

    // Frame is a precomputed list of line levels; pos walks through it.
    function automatic mdl_t step(mdl_t m, logic e, logic [7:0] d,
                                  int ns, logic podd);
        mdl_t r;
        r = m;
        r.done = 1'b0;
        if (m.pos == 0) begin
            r.tx   = 1'b1;
            r.busy = 1'b0;
            if (e) begin
                r.bits    = '1;
                r.bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) r.bits[1+i] = d[i];
                if (PEN == 1) r.bits[9] = (^d) ^ podd;
                r.len  = 9 + PEN + ns;
                r.pos  = 1;
                r.tx   = 1'b0;
                r.busy = 1'b1;
                r.err  = 1'b0;
            end
        end else begin
            if (e) r.err = 1'b1;
            if (m.pos == m.len) begin
                r.pos  = 0;
                r.busy = 1'b0;
                r.done = 1'b1;
                r.tx   = 1'b1;
            end else begin
                r.tx  = m.bits[m.pos];
                r.pos = m.pos + 1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge baud or negedge reset) begin
        if (!reset) begin
            m1 <= idle_m();
            m2 <= idle_m();
        end else begin
            m1 <= step(m1, en, data, 1, 1'b0);
            m2 <= step(m2, en, data, 2, 1'b1);
        end
    end

    always @(negedge baud) begin
        chk("d1.tx",    32'(tx1),   32'(m1.tx));
        chk("d1.busy",  32'(busy1), 32'(m1.busy));
        chk("d1.done",  32'(done1), 32'(m1.done));
        chk("d1.error", 32'(err1),  32'(m1.err));
        chk("d2.tx",    32'(tx2),   32'(m2.tx));
        chk("d2.busy",  32'(busy2), 32'(m2.busy));
        chk("d2.done",  32'(done2), 32'(m2.done));
        chk("d2.error", 32'(err2),  32'(m2.err));
    end

    task automatic send(input logic [7:0] d, output logic [15:0] t1,
                        output logic [15:0] t2, output int b1,
                        output int dn1);
        en   = 1'b1;
        data = d;
        @(posedge baud);
        #2;
        en   = 1'b0;
        data = ~d;
        b1   = 0;
        dn1  = -1;
        t1   = '0;
        t2   = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge baud);
            t1[i] = tx1;
            t2[i] = tx2;
            if (busy1) b1++;
            if (done1 && dn1 < 0) dn1 = i;
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".tx1"},   32'(tx1),   32'd1);
        chk({nm, ".busy1"}, 32'(busy1), 32'd0);
        chk({nm, ".done1"}, 32'(done1), 32'd0);
        chk({nm, ".err1"},  32'(err1),  32'd0);
        chk({nm, ".tx2"},   32'(tx2),   32'd1);
        chk({nm, ".busy2"}, 32'(busy2), 32'd0);
        chk({nm, ".err2"},  32'(err2),  32'd0);
    endtask

    logic [15:0] t1, t2;
    logic [31:0] rec;
    logic        dn;
    int          b1, dn1;

    initial begin
        #1 reset = 1'b0;
        #1 chk_reset_outs("reset");
        #21 reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge baud);
            chk_reset_outs("idle");
        end
        @(posedge baud);
        #2;

        send(8'hA5, t1, t2, b1, dn1);
`ifdef UART_TX_PARITY_EN
        chk("a5.frame1", 32'(t1[10:0]), 32'(11'b10101001010));
        chk("a5.frame2", 32'(t2[11:0]), 32'(12'b111101001010));
`else
        chk("a5.frame1", 32'(t1[9:0]),  32'(10'b1101001010));
        chk("a5.frame2", 32'(t2[10:0]), 32'(11'b11101001010));
`endif
        chk("a5.busy_cycles", 32'(b1), 32'(10 + PEN));
        chk("a5.done_index", 32'(dn1), 32'(10 + PEN));

        send(8'h01, t1, t2, b1, dn1);
`ifdef UART_TX_PARITY_EN
        chk("01.frame1", 32'(t1[10:0]), 32'(11'b11000000010));
`else
        chk("01.frame1", 32'(t1[9:0]),  32'(10'b1000000010));
`endif

        send(8'h5A, t1, t2, b1, dn1);
`ifdef UART_TX_PARITY_EN
        chk("5a.frame2", 32'(t2[11:0]), 32'(12'b111010110100));
`else
        chk("5a.frame2", 32'(t2[10:0]), 32'(11'b11010110100));
`endif

        // Collision: a second strobe mid-frame is dropped and flagged.
        en   = 1'b1;
        data = 8'h3C;
        @(posedge baud);
        #2 en = 1'b0;
        repeat (3) @(posedge baud);
        #2 en = 1'b1;
        @(posedge baud);
        #2 en = 1'b0;
        repeat (14) @(posedge baud);
        #2;
        chk("coll.err1", 32'(err1), 32'd1);
        chk("coll.err2", 32'(err2), 32'd1);
        send(8'hA5, t1, t2, b1, dn1);
        chk("coll.clear1", 32'(err1), 32'd0);
        chk("coll.clear2", 32'(err2), 32'd0);
`ifdef UART_TX_PARITY_EN
        chk("coll.frame1", 32'(t1[10:0]), 32'(11'b10101001010));
`else
        chk("coll.frame1", 32'(t1[9:0]),  32'(10'b1101001010));
`endif

        // Back-to-back: en held through the done cycle.
        @(posedge baud);
        #2;
        en   = 1'b1;
        data = 8'h00;
        rec  = '0;
        dn   = 1'b0;
        @(posedge baud);
        #2 data = 8'hFF;
        for (int i = 0; i < 22; i++) begin
            @(negedge baud);
            rec[i] = tx1;
            if (i == 10 + PEN) dn = done1;
            @(posedge baud);
            #2;
            if (i == 10 + PEN) en = 1'b0;
        end
        chk("b2b.done_gap", 32'(dn), 32'd1);
`ifndef UART_TX_PARITY_EN
        chk("b2b.frames", 32'(rec[21:0]), 32'(22'b1111111111011000000000));
`endif
        repeat (16) @(posedge baud);
        #2;

        // Reset during data bit 3 of 0xA5 (a 0 bit).
        en   = 1'b1;
        data = 8'hA5;
        @(posedge baud);
        #2 en = 1'b0;
        repeat (4) @(posedge baud);
        @(negedge baud);
        chk("mid.bit3", 32'(tx1), 32'd0);
        #2 reset = 1'b0;
        #1 chk_reset_outs("midreset");
        chk("midreset.done2", 32'(done2), 32'd0);
        @(posedge baud);
        #2 reset = 1'b1;
        @(posedge baud);
        #2;
        send(8'hA5, t1, t2, b1, dn1);
`ifdef UART_TX_PARITY_EN
        chk("post.frame1", 32'(t1[10:0]), 32'(11'b10101001010));
`else
        chk("post.frame1", 32'(t1[9:0]),  32'(10'b1101001010));
`endif
        chk("post.done_index", 32'(dn1), 32'(10 + PEN));

        repeat (3) @(posedge baud);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
